// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage sitting directly in front of the control unit.
// Samples the PC from the PC updater, issues a single word read on the
// instruction-memory req/gnt/rvalid bus and presents the returned word to the
// decoder. The word is held until the decoder accepts it. The stage also
// handles redirect flushes, bus errors, misaligned PCs and response timeouts.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   en_i           fetch enable; 0 lets the current access drain, then idles
//   pc_i           fetch address from the PC updater
//   flush_i        redirect; discards the in-flight or held instruction
//   inst_ready_i   decoder accepts inst_o this cycle
//   inst_o         instruction word to the decoder
//   inst_valid_o   inst_o / fetch_pc_o / fault_o are valid
//   fetch_pc_o     address inst_o was fetched from
//   fault_o        00 none, 01 misaligned, 10 bus error, 11 timeout
//   imem_req_o     memory request
//   imem_addr_o    word-aligned request address
//   imem_gnt_i     request accepted this cycle
//   imem_rvalid_i  response valid (earliest one cycle after the grant)
//   imem_rdata_i   response data
//   imem_err_i     response error, qualified by imem_rvalid_i
//
// TO_W must be wide enough that 2**TO_W > TIMEOUT.
// -----------------------------------------------------------------------------
module inst_fetch #(
   parameter logic [31:0] NOP_INST = 32'h0000_0013,
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned TO_W     = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   input  logic [31:0] pc_i,
   input  logic        flush_i,
   input  logic        inst_ready_i,
   output logic [31:0] inst_o,
   output logic        inst_valid_o,
   output logic [31:0] fetch_pc_o,
   output logic [1:0]  fault_o,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        imem_err_i
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_MISALIGN = 2'b01;
   localparam logic [1:0] FAULT_BUS      = 2'b10;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

   localparam logic [TO_W-1:0] TIMEOUT_C = TO_W'(TIMEOUT);

   logic [1:0]      state_q,      state_d;
   logic [31:0]     addr_q,       addr_d;     // full sampled PC, low bits kept for fetch_pc
   logic            req_q,        req_d;
   logic [TO_W-1:0] cnt_q,        cnt_d;
   logic            discard_q,    discard_d;  // response of the current access must be dropped
   logic [31:0]     inst_q,       inst_d;
   logic            inst_valid_q, inst_valid_d;
   logic [31:0]     fetch_pc_q,   fetch_pc_d;
   logic [1:0]      fault_q,      fault_d;

   logic            start_issue;
   logic            deliver;
   logic [31:0]     deliver_inst;
   logic [1:0]      deliver_fault;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      req_d         = req_q;
      cnt_d         = cnt_q;
      discard_d     = discard_q;
      inst_d        = inst_q;
      inst_valid_d  = inst_valid_q;
      fetch_pc_d    = fetch_pc_q;
      fault_d       = fault_q;
      start_issue   = 1'b0;
      deliver       = 1'b0;
      deliver_inst  = NOP_INST;
      deliver_fault = FAULT_NONE;

      case (state_q)
         S_IDLE: begin
            if (en_i) begin
               start_issue = 1'b1;
            end
         end

         S_ISSUE: begin
            if (!req_q) begin
               // Misaligned PC: nothing went out on the bus. A redirect in this
               // cycle simply re-samples the PC instead of reporting the fault.
               if (flush_i) begin
                  start_issue = 1'b1;
               end else begin
                  deliver       = 1'b1;
                  deliver_fault = FAULT_MISALIGN;
               end
            end else begin
               // The request is never retracted; a redirect only marks the
               // eventual response for discard.
               if (flush_i) begin
                  discard_d = 1'b1;
               end
               if (imem_gnt_i) begin
                  state_d = S_WAIT;
                  req_d   = 1'b0;
                  cnt_d   = '0;
               end
            end
         end

         S_WAIT: begin
            if (flush_i) begin
               discard_d = 1'b1;
            end
            if (imem_rvalid_i || (cnt_q == TIMEOUT_C)) begin
               if (discard_q || flush_i) begin
                  start_issue = 1'b1;
               end else begin
                  deliver = 1'b1;
                  if (imem_rvalid_i) begin
                     if (imem_err_i) begin
                        deliver_fault = FAULT_BUS;
                     end else begin
                        deliver_inst  = imem_rdata_i;
                     end
                  end else begin
                     deliver_fault = FAULT_TIMEOUT;
                  end
               end
            end else begin
               cnt_d = cnt_q + TO_W'(1);
            end
         end

         default: begin // S_HOLD
            // Flush takes priority over a same-cycle acceptance.
            if (flush_i) begin
               inst_valid_d = 1'b0;
               start_issue  = 1'b1;
            end else if (inst_ready_i) begin
               // One bubble in IDLE lets the PC updater advance before the
               // next PC is sampled on ISSUE entry.
               inst_valid_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
      endcase

      if (start_issue) begin
         state_d   = S_ISSUE;
         addr_d    = pc_i;
         req_d     = (pc_i[1:0] == 2'b00);
         discard_d = 1'b0;
      end

      if (deliver) begin
         state_d      = S_HOLD;
         inst_d       = deliver_inst;
         fault_d      = deliver_fault;
         fetch_pc_d   = addr_q;
         inst_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         req_q        <= 1'b0;
         cnt_q        <= '0;
         discard_q    <= 1'b0;
         inst_q       <= NOP_INST;
         inst_valid_q <= 1'b0;
         fetch_pc_q   <= '0;
         fault_q      <= FAULT_NONE;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         req_q        <= req_d;
         cnt_q        <= cnt_d;
         discard_q    <= discard_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         fetch_pc_q   <= fetch_pc_d;
         fault_q      <= fault_d;
      end
   end

   assign inst_o       = inst_q;
   assign inst_valid_o = inst_valid_q;
   assign fetch_pc_o   = fetch_pc_q;
   assign fault_o      = fault_q;
   assign imem_req_o   = req_q;
   assign imem_addr_o  = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch. A table of fetch transactions plus
// randomized transactions are run through a task that plays the memory side
// of the bus; expected results come from a rule-level reference function.
// Hand-written sequences cover reset latency, flushes, enable drop and a
// reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        en_i;
   logic [31:0] pc_i;
   logic        flush_i;
   logic        inst_ready_i;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic [31:0] fetch_pc_o;
   logic [1:0]  fault_o;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        imem_err_i;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   inst_fetch dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .en_i         (en_i),
      .pc_i         (pc_i),
      .flush_i      (flush_i),
      .inst_ready_i (inst_ready_i),
      .inst_o       (inst_o),
      .inst_valid_o (inst_valid_o),
      .fetch_pc_o   (fetch_pc_o),
      .fault_o      (fault_o),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_gnt_i   (imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i (imem_rdata_i),
      .imem_err_i   (imem_err_i)
   );

   typedef struct {
      logic [31:0] pc;
      int          gdly;    // cycles gnt is held low
      int          rdly;    // cycles from gnt edge to rvalid (>=1)
      bit          err;
      bit          norsp;   // never respond -> timeout
      int          rdy;     // cycles inst_ready is held low in HOLD
      logic [31:0] e_inst;
      logic [1:0]  e_fault;
      logic [31:0] e_pc;
   } vec_t;

   // Instruction memory contents seen by the bench.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'd2654435761) ^ 32'h1357_9BDF;
   endfunction

   // Reference model: outcome of one fetch derived from the fetch rules.
   function automatic vec_t make_vec(input logic [31:0] pc, input int gdly, input int rdly,
                                     input bit err, input bit norsp, input int rdy);
      vec_t v;
      v.pc = pc; v.gdly = gdly; v.rdly = rdly; v.err = err; v.norsp = norsp; v.rdy = rdy;
      v.e_pc = pc;
      if (pc[1:0] != 2'b00) begin
         v.e_inst = NOP; v.e_fault = 2'b01;
      end else if (norsp) begin
         v.e_inst = NOP; v.e_fault = 2'b11;
      end else if (err) begin
         v.e_inst = NOP; v.e_fault = 2'b10;
      end else begin
         v.e_inst = mem_word(pc); v.e_fault = 2'b00;
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_req(input string name);
      int n;
      n = 0;
      while (!imem_req_o && n < 20) begin step(); n++; end
      chk(name, 32'(imem_req_o), 32'd1);
   endtask

   // Runs one complete fetch: drives pc, answers the bus, checks the result,
   // holds ready low for v.rdy cycles, then accepts.
   task automatic run_txn(input vec_t v, input bit drop_en);
      int          n;
      logic [31:0] a;
      pc_i = v.pc;
      n = 0;
      while (!imem_req_o && !inst_valid_o && n < 20) begin step(); n++; end
      chk("issue_seen", 32'(imem_req_o | inst_valid_o), 32'd1);
      if (drop_en) en_i = 1'b0;
      if (imem_req_o) begin
         a = imem_addr_o;
         chk("req_addr", a, {v.pc[31:2], 2'b00});
         for (int i = 0; i < v.gdly; i++) begin
            step();
            chk("req_hold", 32'(imem_req_o), 32'd1);
            chk("addr_hold", imem_addr_o, a);
         end
         imem_gnt_i = 1'b1;
         step();
         imem_gnt_i = 1'b0;
         chk("req_drop", 32'(imem_req_o), 32'd0);
         if (!v.norsp) begin
            for (int i = 0; i < v.rdly - 1; i++) step();
            imem_rvalid_i = 1'b1;
            imem_err_i    = v.err;
            imem_rdata_i  = mem_word(a);
            step();
            imem_rvalid_i = 1'b0;
            imem_err_i    = 1'b0;
            imem_rdata_i  = '0;
         end else begin
            n = 0;
            while (!inst_valid_o && n < 400) begin step(); n++; end
            chk("timeout_lat", 32'((n >= 255) && (n <= 257)), 32'd1);
         end
      end
      n = 0;
      while (!inst_valid_o && n < 10) begin step(); n++; end
      chk("valid_seen", 32'(inst_valid_o), 32'd1);
      chk("inst", inst_o, v.e_inst);
      chk("fault", 32'(fault_o), 32'(v.e_fault));
      chk("fetch_pc", fetch_pc_o, v.e_pc);
      if (v.norsp) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = 32'hDEAD_BEEF;
         step();
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = '0;
         chk("late_rvalid_inst", inst_o, NOP);
         chk("late_rvalid_fault", 32'(fault_o), 32'd3);
      end
      for (int i = 0; i < v.rdy; i++) begin
         step();
         chk("hold_valid", 32'(inst_valid_o), 32'd1);
         chk("hold_inst", inst_o, v.e_inst);
         chk("hold_pc", fetch_pc_o, v.e_pc);
      end
      $display("txn pc=0x%08h inst=0x%08h fault=%0d fetch_pc=0x%08h",
               v.pc, inst_o, fault_o, fetch_pc_o);
      inst_ready_i = 1'b1;
      step();
      inst_ready_i = 1'b0;
      chk("valid_drop", 32'(inst_valid_o), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   vec_t tbl[6];
   vec_t rv;

   initial begin
      tbl[0] = make_vec(32'h0000_0102, 0, 1, 1'b0, 1'b0, 0);
      tbl[1] = make_vec(32'h0000_0040, 4, 1, 1'b0, 1'b0, 0);
      tbl[2] = make_vec(32'h0000_0044, 0, 2, 1'b1, 1'b0, 1);
      tbl[3] = make_vec(32'h0000_0048, 1, 1, 1'b0, 1'b1, 0);
      tbl[4] = make_vec(32'h0000_004C, 0, 1, 1'b0, 1'b0, 5);
      tbl[5] = make_vec(32'h0000_0050, 2, 3, 1'b0, 1'b0, 2);

      rst_ni = 1'b0; en_i = 1'b1; pc_i = 32'h0; flush_i = 1'b0; inst_ready_i = 1'b0;
      imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; imem_err_i = 1'b0;

      // Reset state, then best-case latency from reset release.
      repeat (3) step();
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_addr", imem_addr_o, 32'd0);
      chk("rst_inst", inst_o, NOP);
      chk("rst_valid", 32'(inst_valid_o), 32'd0);
      chk("rst_fetch_pc", fetch_pc_o, 32'd0);
      chk("rst_fault", 32'(fault_o), 32'd0);
      rst_ni = 1'b1;                              // cycle 0
      chk("c0_req", 32'(imem_req_o), 32'd0);
      step();                                     // cycle 1
      chk("c1_req", 32'(imem_req_o), 32'd1);
      chk("c1_addr", imem_addr_o, 32'd0);
      imem_gnt_i = 1'b1;
      step();                                     // cycle 2
      imem_gnt_i = 1'b0;
      chk("c2_req", 32'(imem_req_o), 32'd0);
      chk("c2_valid", 32'(inst_valid_o), 32'd0);
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093;
      step();                                     // cycle 3
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      chk("c3_valid", 32'(inst_valid_o), 32'd1);
      chk("c3_inst", inst_o, 32'h0050_0093);
      chk("c3_fetch_pc", fetch_pc_o, 32'd0);
      chk("c3_fault", 32'(fault_o), 32'd0);
      inst_ready_i = 1'b1;
      step();
      inst_ready_i = 1'b0;
      chk("c4_valid", 32'(inst_valid_o), 32'd0);

      foreach (tbl[i]) run_txn(tbl[i], 1'b0);

      // Flush while waiting for the response: the old word must never appear.
      pc_i = 32'h10;
      wait_req("fw_req");
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0;
      flush_i = 1'b1; pc_i = 32'h80;
      step();
      flush_i = 1'b0;
      chk("fw_valid0", 32'(inst_valid_o), 32'd0);
      imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h10);
      step();
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      chk("fw_valid1", 32'(inst_valid_o), 32'd0);
      run_txn(make_vec(32'h80, 0, 1, 1'b0, 1'b0, 0), 1'b0);

      // Flush in HOLD together with inst_ready: the held word is dropped.
      pc_i = 32'h90;
      wait_req("fh_req");
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0;
      imem_rvalid_i = 1'b1; imem_rdata_i = mem_word(32'h90);
      step();
      imem_rvalid_i = 1'b0; imem_rdata_i = '0;
      chk("fh_valid", 32'(inst_valid_o), 32'd1);
      flush_i = 1'b1; inst_ready_i = 1'b1; pc_i = 32'h200;
      step();
      flush_i = 1'b0; inst_ready_i = 1'b0;
      chk("fh_drop", 32'(inst_valid_o), 32'd0);
      run_txn(make_vec(32'h200, 1, 2, 1'b0, 1'b0, 0), 1'b0);

      // Enable dropped mid-access: delivers, then stays idle.
      run_txn(make_vec(32'h60, 1, 1, 1'b0, 1'b0, 1), 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("en0_idle_req", 32'(imem_req_o), 32'd0);
         chk("en0_idle_valid", 32'(inst_valid_o), 32'd0);
      end
      en_i = 1'b1;

      // Randomized transactions against the reference model.
      for (int t = 0; t < 40; t++) begin
         logic [31:0] p;
         p = $urandom & 32'h000F_FFFC;
         if ($urandom_range(0, 5) == 0) p[1:0] = 2'($urandom_range(1, 3));
         rv = make_vec(p, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
                       ($urandom_range(0, 7) == 0), 1'b0, int'($urandom_range(0, 3)));
         run_txn(rv, 1'b0);
      end

      // Reset asserted while waiting for a response.
      pc_i = 32'h300;
      wait_req("rw_req");
      imem_gnt_i = 1'b1;
      step();
      imem_gnt_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      chk("rw_req0", 32'(imem_req_o), 32'd0);
      chk("rw_addr", imem_addr_o, 32'd0);
      chk("rw_inst", inst_o, NOP);
      chk("rw_valid", 32'(inst_valid_o), 32'd0);
      chk("rw_fetch_pc", fetch_pc_o, 32'd0);
      chk("rw_fault", 32'(fault_o), 32'd0);
      step();
      rst_ni = 1'b1;
      run_txn(make_vec(32'h304, 0, 1, 1'b0, 1'b0, 0), 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
